// File: rtl/medusa_pkg.sv
// Shared constants and types for the Medusa cape LED PWM path.
//   VALUE_W   : width of a gamma-corrected brightness value
//   PWM_STEPS : steps per PWM period (0..PWM_MAX)
//   PWM_MAX   : last step value before the counter wraps
//   commit_state_e : shadow->active commit FSM states
package medusa_pkg;
  localparam int VALUE_W   = 8;
  localparam int PWM_STEPS = 255;
  localparam int PWM_MAX   = 254;

  typedef enum logic {
    OPEN    = 1'b0,
    PENDING = 1'b1
  } commit_state_e;
endpackage

// File: rtl/tick_divider.sv
// Programmable prescaler: emits one tick every prescale_i+1 clocks.
//   clk, reset  : clock, synchronous active-high reset
//   prescale_i  : divide ratio minus one
//   tick_o      : combinational tick, high in the clock where pre_cnt >= prescale_i
module tick_divider #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  w_tick;

  // >= rather than == so a prescale drop below the running count fires at
  // once instead of waiting for a counter wrap.
  assign w_tick = (r_pre_cnt >= prescale_i);
  assign tick_o = w_tick;

  always_ff @(posedge clk) begin
    if (reset)       r_pre_cnt <= '0;
    else if (w_tick) r_pre_cnt <= '0;
    else             r_pre_cnt <= r_pre_cnt + 1'b1;
  end
endmodule

// File: rtl/led_pwm.sv
// Multi-channel LED PWM with shadow/active brightness banks.
//   clk, reset        : clock, synchronous active-high reset
//   prescale_i        : one PWM step every prescale_i+1 clocks
//   load_valid_i/ready_o, load_channel_i, load_value_i : shadow write handshake
//   commit_i          : request shadow->active swap at the next period boundary
//   commit_pending_o  : swap requested and not yet performed
//   period_start_o    : pulse aligned with the first pwm_o of each period
//   pwm_o             : registered LED drive bits
module led_pwm
  import medusa_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int PRESCALE_W = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [CH_W-1:0]       load_channel_i,
  input  logic [VALUE_W-1:0]    load_value_i,
  input  logic                  commit_i,
  output logic                  commit_pending_o,
  output logic                  period_start_o,
  output logic [CHANNELS-1:0]   pwm_o
);
  logic [VALUE_W-1:0]               r_cnt;
  logic [CHANNELS-1:0][VALUE_W-1:0] r_shadow;
  logic [CHANNELS-1:0][VALUE_W-1:0] r_active;
  logic [CHANNELS-1:0]              r_pwm;
  logic [1:0]                       r_bnd_pipe;
  commit_state_e                    r_state, w_state_nxt;
  logic w_tick, w_boundary, w_swap, w_load_fire, w_ch_ok;

  tick_divider #(.PRESCALE_W(PRESCALE_W)) u_div (
    .clk        (clk),
    .reset      (reset),
    .prescale_i (prescale_i),
    .tick_o     (w_tick)
  );

  assign w_boundary = w_tick && (r_cnt == VALUE_W'(PWM_MAX));
  assign w_swap     = (r_state == PENDING) && w_boundary;
  // Out-of-range channels still complete the handshake; the write is dropped.
  assign w_ch_ok     = ({1'b0, load_channel_i} < (CH_W+1)'(CHANNELS));
  assign w_load_fire = load_valid_i && load_ready_o && w_ch_ok;

  always_ff @(posedge clk) begin
    if (reset)           r_cnt <= '0;
    else if (w_boundary) r_cnt <= '0;
    else if (w_tick)     r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= OPEN;
    else       r_state <= w_state_nxt;
  end

  // A commit seen on the boundary cycle itself only enters PENDING, so the
  // swap lands on the following boundary, never the current one.
  always_comb begin
    w_state_nxt      = r_state;
    load_ready_o     = 1'b1;
    commit_pending_o = 1'b0;
    case (r_state)
      OPEN: begin
        if (commit_i) w_state_nxt = PENDING;
      end
      PENDING: begin
        load_ready_o     = 1'b0;
        commit_pending_o = 1'b1;
        if (w_boundary) w_state_nxt = OPEN;
      end
      default: w_state_nxt = OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_load_fire && (load_channel_i == CH_W'(i))) r_shadow[i] <= load_value_i;
        if (w_swap) r_active[i] <= r_shadow[i];
        r_pwm[i] <= (r_cnt < r_active[i]);
      end
    end
  end

  // Two stages: cnt/active update on the boundary edge, pwm_o one edge later.
  always_ff @(posedge clk) begin
    if (reset) r_bnd_pipe <= '0;
    else       r_bnd_pipe <= {r_bnd_pipe[0], w_boundary};
  end

  assign period_start_o = r_bnd_pipe[1];
  assign pwm_o          = r_pwm;
endmodule

// File: tb/tb_led_pwm.sv
module tb_led_pwm;
  localparam int CHANNELS   = 6;
  localparam int PRESCALE_W = 4;
  localparam int CH_W       = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PRESCALE_W-1:0] prescale_i;
  logic                  load_valid_i;
  logic                  load_ready_o;
  logic [CH_W-1:0]       load_channel_i;
  logic [7:0]            load_value_i;
  logic                  commit_i;
  logic                  commit_pending_o;
  logic                  period_start_o;
  logic [CHANNELS-1:0]   pwm_o;

  led_pwm #(.CHANNELS(CHANNELS), .PRESCALE_W(PRESCALE_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .prescale_i       (prescale_i),
    .load_valid_i     (load_valid_i),
    .load_ready_o     (load_ready_o),
    .load_channel_i   (load_channel_i),
    .load_value_i     (load_value_i),
    .commit_i         (commit_i),
    .commit_pending_o (commit_pending_o),
    .period_start_o   (period_start_o),
    .pwm_o            (pwm_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hi_cnt[CHANNELS];
  int first_hi0, last_hi0, per_len, pend_seen, e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int ch, input int val, input bit cmt);
    load_valid_i   = 1'b1;
    load_channel_i = CH_W'(ch);
    load_value_i   = 8'(val);
    commit_i       = cmt;
    step();
    load_valid_i = 1'b0;
    commit_i     = 1'b0;
  endtask

  task automatic do_commit();
    commit_i = 1'b1;
    step();
    commit_i = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start_o && n < budget);
    if (!period_start_o) begin
      checks++; errors++;
      $display("FAIL period_start_timeout: none within %0d clocks", budget);
    end
  endtask

  // Samples from the current (period-start) clock up to the next period start.
  task automatic measure_period(input int budget);
    per_len = 0; pend_seen = 0; first_hi0 = -1; last_hi0 = -1;
    for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
    do begin
      for (int c = 0; c < CHANNELS; c++) if (pwm_o[c]) hi_cnt[c]++;
      if (pwm_o[0]) begin
        if (first_hi0 < 0) first_hi0 = per_len;
        last_hi0 = per_len;
      end
      if (commit_pending_o) pend_seen++;
      per_len++;
      step();
    end while (!period_start_o && per_len < budget);
    if (!period_start_o) begin
      checks++; errors++;
      $display("FAIL period_end_timeout: none within %0d clocks", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; prescale_i = '0; load_valid_i = 1'b0; load_channel_i = '0;
    load_value_i = '0; commit_i = 1'b0;
    repeat (3) step();
    checks++; if (pwm_o !== '0) begin errors++; $display("FAIL reset_pwm got %b exp 0", pwm_o); end
    checks++; if (period_start_o !== 1'b0) begin errors++; $display("FAIL reset_ps got %b exp 0", period_start_o); end
    checks++; if (load_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", load_ready_o); end
    checks++; if (commit_pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", commit_pending_o); end
    reset = 1'b0;
  endtask

  task automatic test_basic_duty();
    int n;
    do_load(0, 128, 1'b0); exp_q.push_back(128);
    do_load(1, 0,   1'b0); exp_q.push_back(0);
    do_load(2, 255, 1'b1); exp_q.push_back(255);   // load + commit same cycle
    exp_q.push_back(255);                          // period length
    checks++; if (commit_pending_o !== 1'b1 || load_ready_o !== 1'b0) begin
      errors++; $display("FAIL basic_pending got pend=%b rdy=%b exp 1/0", commit_pending_o, load_ready_o);
    end
    wait_ps(600, n);
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL basic_ch0 got %0d exp %0d", hi_cnt[0], e); end
    e = exp_q.pop_front(); checks++; if (hi_cnt[1] !== e) begin errors++; $display("FAIL basic_ch1 got %0d exp %0d", hi_cnt[1], e); end
    e = exp_q.pop_front(); checks++; if (hi_cnt[2] !== e) begin errors++; $display("FAIL basic_ch2 got %0d exp %0d", hi_cnt[2], e); end
    e = exp_q.pop_front(); checks++; if (per_len !== e) begin errors++; $display("FAIL basic_period got %0d exp %0d", per_len, e); end
  endtask

  task automatic test_prescale();
    int n;
    prescale_i = 4'd3;
    do_load(0, 1, 1'b0);
    do_commit();
    exp_q.push_back(1020); exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(3);
    wait_ps(2100, n);
    measure_period(2100);
    prescale_i = 4'd0;
    e = exp_q.pop_front(); checks++; if (per_len !== e) begin errors++; $display("FAIL pre_period got %0d exp %0d", per_len, e); end
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL pre_ch0_high got %0d exp %0d", hi_cnt[0], e); end
    e = exp_q.pop_front(); checks++; if (first_hi0 !== e) begin errors++; $display("FAIL pre_first_high got %0d exp %0d", first_hi0, e); end
    e = exp_q.pop_front(); checks++; if (last_hi0 !== e) begin errors++; $display("FAIL pre_last_high got %0d exp %0d", last_hi0, e); end
  endtask

  task automatic test_load_while_pending();
    int n;
    do_commit();
    checks++; if (load_ready_o !== 1'b0) begin errors++; $display("FAIL pend_ready got %b exp 0", load_ready_o); end
    load_valid_i = 1'b1; load_channel_i = '0; load_value_i = 8'd50;
    exp_q.push_back(1);   // old shadow value survives the swap
    exp_q.push_back(50);  // held load lands once the bank reopens
    n = 0;
    while (load_ready_o !== 1'b1 && n < 1100) begin step(); n++; end
    checks++; if (load_ready_o !== 1'b1 || commit_pending_o !== 1'b0) begin
      errors++; $display("FAIL pend_reopen got rdy=%b pend=%b exp 1/0", load_ready_o, commit_pending_o);
    end
    step();
    load_valid_i = 1'b0;
    checks++; if (period_start_o !== 1'b1) begin errors++; $display("FAIL pend_ps_align got %b exp 1", period_start_o); end
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL pend_old_ch0 got %0d exp %0d", hi_cnt[0], e); end
    do_commit();
    wait_ps(600, n);
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL pend_new_ch0 got %0d exp %0d", hi_cnt[0], e); end
  endtask

  task automatic test_commit_on_boundary();
    do_load(0, 200, 1'b0);
    exp_q.push_back(50); exp_q.push_back(254); exp_q.push_back(200);
    repeat (252) step();          // now in the boundary clock
    do_commit();
    checks++; if (commit_pending_o !== 1'b1) begin errors++; $display("FAIL bnd_pending got %b exp 1", commit_pending_o); end
    step();
    checks++; if (period_start_o !== 1'b1) begin errors++; $display("FAIL bnd_ps got %b exp 1", period_start_o); end
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL bnd_no_swap got %0d exp %0d", hi_cnt[0], e); end
    e = exp_q.pop_front(); checks++; if (pend_seen !== e) begin errors++; $display("FAIL bnd_pend_cycles got %0d exp %0d", pend_seen, e); end
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[0] !== e) begin errors++; $display("FAIL bnd_swap got %0d exp %0d", hi_cnt[0], e); end
  endtask

  task automatic test_out_of_range();
    int n;
    int exp_v[CHANNELS] = '{200, 0, 255, 0, 0, 0};
    checks++; if (load_ready_o !== 1'b1) begin errors++; $display("FAIL oor_ready got %b exp 1", load_ready_o); end
    do_load(CHANNELS, 200, 1'b0);
    for (int c = 0; c < CHANNELS; c++) exp_q.push_back(exp_v[c]);
    do_commit();
    wait_ps(600, n);
    measure_period(600);
    for (int c = 0; c < CHANNELS; c++) begin
      e = exp_q.pop_front(); checks++;
      if (hi_cnt[c] !== e) begin errors++; $display("FAIL oor_ch%0d got %0d exp %0d", c, hi_cnt[c], e); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_commit();
    repeat (98) step();           // cnt == 100 here
    checks++; if (commit_pending_o !== 1'b1) begin errors++; $display("FAIL rst_pre_pend got %b exp 1", commit_pending_o); end
    exp_q.push_back(256); exp_q.push_back(0);
    reset = 1'b1;
    step();
    checks++; if (pwm_o !== '0) begin errors++; $display("FAIL rst_pwm got %b exp 0", pwm_o); end
    checks++; if (commit_pending_o !== 1'b0) begin errors++; $display("FAIL rst_pend got %b exp 0", commit_pending_o); end
    checks++; if (load_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", load_ready_o); end
    reset = 1'b0;
    wait_ps(600, n);
    e = exp_q.pop_front(); checks++; if (n !== e) begin errors++; $display("FAIL rst_cnt_restart got %0d exp %0d", n, e); end
    measure_period(600);
    e = exp_q.pop_front(); checks++; if (hi_cnt[2] !== e) begin errors++; $display("FAIL rst_active_clr got %0d exp %0d", hi_cnt[2], e); end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_prescale();
    test_load_while_pending();
    test_commit_on_boundary();
    test_out_of_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
